// File: rtl/div_result_bcd.sv
// div_result_bcd
//   Captures the divider's quotient/remainder on each rising edge of
//   div_ready. It converts both values to packed BCD by sequential
//   double-dabble (shift-add-3), one bit per clock, with both values
//   processed in parallel. The result is presented with a one-cycle done pulse.
// Parameters
//   WIDTH   binary operand width (must be <= 9 so the result fits in DIGITS)
//   DIGITS  BCD digits per result; BCD outputs are 4*DIGITS bits wide
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   div_ready  divider ready; rising edge marks a new result
//   quotient   divider quotient (valid while div_ready=1)
//   remainder  divider remainder (valid while div_ready=1)
//   divisor    divisor applied to the divider
//   q_bcd      packed BCD quotient, [3:0] = units digit
//   r_bcd      packed BCD remainder, [3:0] = units digit
//   div_zero   presented result had divisor == 0
//   busy       conversion in progress
//   done       one-cycle pulse when q_bcd/r_bcd/div_zero update
//   overrun    sticky: a result edge arrived while busy
module div_result_bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  div_ready,
  input  logic [WIDTH-1:0]      quotient,
  input  logic [WIDTH-1:0]      remainder,
  input  logic [WIDTH-1:0]      divisor,
  output logic [4*DIGITS-1:0]   q_bcd,
  output logic [4*DIGITS-1:0]   r_bcd,
  output logic                  div_zero,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic            ready_d;
  logic            edge_det;
  logic [SW-1:0]   q_scr, r_scr;
  logic [SW-1:0]   q_nxt, r_nxt;
  logic            zero_scr;

  // One double-dabble iteration on the {bcd, bin} scratch: correct every
  // BCD nibble >= 5 by adding 3, then shift the whole word left by one.
  function automatic logic [SW-1:0] dabble_step(input logic [SW-1:0] s);
    logic [SW-1:0] t;
    t = s;
    for (int d = 0; d < DIGITS; d++) begin
      if (t[WIDTH + 4*d +: 4] >= 4'd5)
        t[WIDTH + 4*d +: 4] = t[WIDTH + 4*d +: 4] + 4'd3;
    end
    return {t[SW-2:0], 1'b0};
  endfunction

  assign edge_det = div_ready & ~ready_d;

  always_comb begin
    q_nxt = dabble_step(q_scr);
    r_nxt = dabble_step(r_scr);
  end

  // Control and presented outputs. ready_d resets high so a div_ready held
  // high across reset is not seen as a fresh result.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_d  <= 1'b1;
      state    <= IDLE;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
      q_bcd    <= '0;
      r_bcd    <= '0;
      div_zero <= 1'b0;
    end else begin
      ready_d <= div_ready;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (edge_det) begin
            count <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // Edges during a conversion are dropped but remembered.
          if (edge_det)
            overrun <= 1'b1;
          count <= count + 1'b1;
          if (count == LAST) begin
            q_bcd    <= q_nxt[SW-1 -: BW];
            r_bcd    <= r_nxt[SW-1 -: BW];
            div_zero <= zero_scr;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Conversion scratch: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && edge_det) begin
      q_scr    <= {{BW{1'b0}}, quotient};
      r_scr    <= {{BW{1'b0}}, remainder};
      zero_scr <= (divisor == '0);
    end else if (state == SHIFT) begin
      q_scr <= q_nxt;
      r_scr <= r_nxt;
    end
  end

endmodule

// File: tb/tb_div_result_bcd.sv
// tb_div_result_bcd
//   Bench for div_result_bcd (WIDTH=8, DIGITS=3). A behavioural model
//   (decimal digit arithmetic plus a conversion timer) predicts every output
//   each cycle; directed scenarios add literal expectations.
module tb_div_result_bcd;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                div_ready;
  logic [WIDTH-1:0]    quotient, remainder, divisor;
  logic [4*DIGITS-1:0] q_bcd, r_bcd;
  logic                div_zero, busy, done, overrun;

  int n_cmp = 0;
  int n_err = 0;

  div_result_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .div_ready(div_ready),
    .quotient(quotient), .remainder(remainder), .divisor(divisor),
    .q_bcd(q_bcd), .r_bcd(r_bcd), .div_zero(div_zero),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference conversion written with decimal arithmetic.
  function automatic int to_bcd(input int v);
    return (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  // ---------------- behavioural model ----------------
  // A capture starts an 8-cycle conversion; the result appears with done
  // after the last of those cycles. Edges inside that window only set overrun.
  int m_q = 0, m_r = 0, m_z = 0, m_busy = 0, m_done = 0, m_ovr = 0;
  int m_timer = 0, m_pq = 0, m_pr = 0, m_pz = 0;
  bit m_rdy_prev = 1'b1;

  always @(posedge clk) begin
    bit e;
    if (rst) begin
      m_q = 0; m_r = 0; m_z = 0; m_busy = 0; m_done = 0; m_ovr = 0;
      m_timer = 0; m_rdy_prev = 1'b1;
    end else begin
      e = div_ready && !m_rdy_prev;
      m_rdy_prev = div_ready;
      m_done = 0;
      if (m_timer > 0) begin
        if (e) m_ovr = 1;
        m_timer--;
        if (m_timer == 0) begin
          m_q = to_bcd(m_pq); m_r = to_bcd(m_pr); m_z = m_pz;
          m_done = 1; m_busy = 0;
        end
      end else if (e) begin
        m_pq = quotient; m_pr = remainder; m_pz = (divisor == 0);
        m_timer = WIDTH; m_busy = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("q_bcd", q_bcd, m_q);
    chk("r_bcd", r_bcd, m_r);
    chk("div_zero", div_zero, m_z);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("overrun", overrun, m_ovr);
    if (done) begin
      for (int i = 0; i < DIGITS; i++) begin
        chk("q_nibble_le9", (q_bcd[4*i +: 4] <= 4'd9), 1);
        chk("r_nibble_le9", (r_bcd[4*i +: 4] <= 4'd9), 1);
      end
    end
  end

  // Drive one result at a negedge, drop ready after one cycle, wait for done.
  // The capture edge E0 is the next posedge; done follows E8, so it is first
  // seen on the 9th negedge after the drive.
  task automatic do_div(input int q, input int r, input int d, output int lat);
    quotient = 8'(q); remainder = 8'(r); divisor = 8'(d);
    div_ready = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) div_ready = 1'b0;
    end while (!done && lat < 40);
    if (!done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int lat, n_done, seen_q, saw_done;
    rst = 1'b1; div_ready = 1'b1;
    quotient = '0; remainder = '0; divisor = 8'd1;

    chk("model_pin_255", to_bcd(255), 'h255);
    chk("model_pin_14", to_bcd(14), 'h014);

    // reset with div_ready held high: no capture after release
    repeat (3) @(negedge clk);
    chk("reset_q_bcd", q_bcd, 0);
    chk("reset_overrun", overrun, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_capture_held_ready", busy, 0);
    div_ready = 1'b0;
    @(negedge clk);

    // 100/7 -> 14 r 2
    do_div(14, 2, 7, lat);
    chk("t1_q", q_bcd, 'h014);
    chk("t1_r", r_bcd, 'h002);
    chk("t1_dz", div_zero, 0);
    chk("t1_latency", lat, 9);
    @(negedge clk);
    chk("t1_done_one_cycle", done, 0);

    // 55/5 -> 11 r 0 (held values checked every cycle by the compare process)
    do_div(11, 0, 5, lat);
    chk("t2_q", q_bcd, 'h011);
    chk("t2_r", r_bcd, 'h000);

    // divide by zero flag, then cleared by the next valid divide
    do_div(255, 25, 0, lat);
    chk("t3_dz_set", div_zero, 1);
    do_div(5, 0, 5, lat);
    chk("t3_dz_clr", div_zero, 0);

    // max values and full sweep
    do_div(255, 199, 1, lat);
    chk("t4_q", q_bcd, 'h255);
    chk("t4_r", r_bcd, 'h199);
    for (int v = 0; v < 256; v++) begin
      do_div(v, 255 - v, v, lat);
      chk("sweep_q", q_bcd, to_bcd(v));
    end

    // random non-overlapping results with random gaps
    for (int k = 0; k < 60; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_div($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3), lat);
    end

    // second edge 3 cycles after the first: dropped, overrun set
    @(negedge clk);
    quotient = 8'd42; remainder = 8'd3; divisor = 8'd9; div_ready = 1'b1;
    @(negedge clk); div_ready = 1'b0;
    @(negedge clk); quotient = 8'd99; remainder = 8'd9;
    @(negedge clk); div_ready = 1'b1;
    @(negedge clk); div_ready = 1'b0;
    n_done = 0; seen_q = -1;
    repeat (16) begin
      @(negedge clk);
      if (done) begin n_done++; seen_q = q_bcd; end
    end
    chk("t5_one_done", n_done, 1);
    chk("t5_first_result", seen_q, 'h042);
    chk("t5_overrun", overrun, 1);
    do_div(7, 7, 7, lat);
    chk("t5_overrun_sticky", overrun, 1);

    // random toggling of div_ready, including edges while busy
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      div_ready = 1'($urandom_range(0, 1));
      quotient = 8'($urandom); remainder = 8'($urandom); divisor = 8'($urandom_range(0, 2));
    end
    div_ready = 1'b0;
    repeat (12) @(negedge clk);

    // reset at iteration 4 with div_ready held high through reset
    quotient = 8'd123; remainder = 8'd45; divisor = 8'd3; div_ready = 1'b1;
    @(negedge clk); div_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1; div_ready = 1'b1;
    saw_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    chk("t6_no_done", saw_done, 0);
    chk("t6_q_zero", q_bcd, 0);
    chk("t6_not_busy", busy, 0);
    chk("t6_overrun_clr", overrun, 0);
    div_ready = 1'b0;
    @(negedge clk);
    do_div(77, 6, 10, lat);
    chk("t6_recover_q", q_bcd, 'h077);
    chk("t6_recover_r", r_bcd, 'h006);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
